// File: rtl/ct_mat_exu_mma_seq.sv
// MMA step sequencer: walks M x N x ceil(K/K_CHUNK) MAC steps over a
// valid/ready handshake, then reports completion over a done handshake.
//
// Ports:
//   forever_cpuclk, cpurst          clock, sync active-high reset
//   idu_mat_mma_start_vld/_rdy      start handshake
//   x_sizeK/M/N                     operation sizes, latched at start
//   rtu_yy_xx_flush                 abort to IDLE, highest priority
//   seq_mac_step_vld/mac_seq_step_rdy, seq_mac_*  MAC step handshake
//   mat_idu_mma_done_vld/_rdy, _zero completion handshake
//   mat_seq_busy, mat_seq_step_cnt  status, saturating step counter
module ct_mat_exu_mma_seq #(
  parameter int K_CHUNK    = 4,
  parameter int KLEN_WIDTH = 3
) (
  input  logic                  forever_cpuclk,
  input  logic                  cpurst,
  input  logic                  idu_mat_mma_start_vld,
  output logic                  mat_idu_mma_start_rdy,
  input  logic [15:0]           x_sizeK,
  input  logic [7:0]            x_sizeM,
  input  logic [7:0]            x_sizeN,
  input  logic                  rtu_yy_xx_flush,
  output logic                  seq_mac_step_vld,
  input  logic                  mac_seq_step_rdy,
  output logic [7:0]            seq_mac_m_idx,
  output logic [7:0]            seq_mac_n_idx,
  output logic [15:0]           seq_mac_k_idx,
  output logic [KLEN_WIDTH-1:0] seq_mac_k_len,
  output logic                  seq_mac_k_first,
  output logic                  seq_mac_k_last,
  output logic                  mat_idu_mma_done_vld,
  input  logic                  idu_mat_mma_done_rdy,
  output logic                  mat_idu_mma_done_zero,
  output logic                  mat_seq_busy,
  output logic [31:0]           mat_seq_step_cnt
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} st_e;

  localparam logic [16:0] KC = 17'(K_CHUNK);

  st_e                   st_q, st_d;
  logic [15:0]           szk_q, szk_d;
  logic [7:0]            szm_q, szm_d;
  logic [7:0]            szn_q, szn_d;
  logic [7:0]            m_q, m_d;
  logic [7:0]            n_q, n_d;
  logic [15:0]           k_q, k_d;
  logic [KLEN_WIDTH-1:0] len_q, len_d;
  logic                  kf_q, kf_d;
  logic                  kl_q, kl_d;
  logic                  dz_q, dz_d;
  logic [31:0]           cnt_q, cnt_d;
  logic                  xfer;

  // Chunk length / last flag of the chunk starting at k. 17-bit math so
  // k + K_CHUNK cannot wrap when sizeK is near 65535.
  function automatic logic [KLEN_WIDTH-1:0] f_len(
    input logic [15:0] k, input logic [15:0] sz);
    logic [16:0] rem;
    rem = {1'b0, sz} - {1'b0, k};
    if (rem >= KC) return KLEN_WIDTH'(K_CHUNK);
    return rem[KLEN_WIDTH-1:0];
  endfunction

  function automatic logic f_last(
    input logic [15:0] k, input logic [15:0] sz);
    return ({1'b0, k} + KC) >= {1'b0, sz};
  endfunction

  assign mat_idu_mma_start_rdy = (st_q == IDLE) && !rtu_yy_xx_flush && !cpurst;
  assign seq_mac_step_vld      = (st_q == RUN);
  assign mat_idu_mma_done_vld  = (st_q == DONE);
  assign mat_idu_mma_done_zero = dz_q;
  assign mat_seq_busy          = (st_q != IDLE);
  assign mat_seq_step_cnt      = cnt_q;
  assign seq_mac_m_idx         = m_q;
  assign seq_mac_n_idx         = n_q;
  assign seq_mac_k_idx         = k_q;
  assign seq_mac_k_len         = len_q;
  assign seq_mac_k_first       = kf_q;
  assign seq_mac_k_last        = kl_q;

  assign xfer = (st_q == RUN) && mac_seq_step_rdy;

  always_comb begin
    st_d  = st_q;
    szk_d = szk_q;
    szm_d = szm_q;
    szn_d = szn_q;
    m_d   = m_q;
    n_d   = n_q;
    k_d   = k_q;
    len_d = len_q;
    kf_d  = kf_q;
    kl_d  = kl_q;
    dz_d  = dz_q;
    cnt_d = cnt_q;
    // A transfer in a flush cycle still counts.
    if (xfer && (cnt_q != 32'hFFFF_FFFF)) cnt_d = cnt_q + 32'd1;
    if (rtu_yy_xx_flush) begin
      st_d = IDLE;
    end else begin
      unique case (st_q)
        IDLE: begin
          if (idu_mat_mma_start_vld && mat_idu_mma_start_rdy) begin
            szk_d = x_sizeK;
            szm_d = x_sizeM;
            szn_d = x_sizeN;
            m_d   = '0;
            n_d   = '0;
            k_d   = '0;
            len_d = f_len(16'd0, x_sizeK);
            kf_d  = 1'b1;
            kl_d  = f_last(16'd0, x_sizeK);
            if (x_sizeK == '0 || x_sizeM == '0 || x_sizeN == '0) begin
              st_d = DONE;
              dz_d = 1'b1;
            end else begin
              st_d = RUN;
              dz_d = 1'b0;
            end
          end
        end
        RUN: begin
          if (xfer) begin
            if (kl_q) begin
              k_d = '0;
              if (n_q == szn_q - 8'd1) begin
                n_d = '0;
                if (m_q == szm_q - 8'd1) begin
                  st_d = DONE;
                  dz_d = 1'b0;
                end else begin
                  m_d = m_q + 8'd1;
                end
              end else begin
                n_d = n_q + 8'd1;
              end
            end else begin
              k_d = k_q + 16'(K_CHUNK);
            end
            len_d = f_len(k_d, szk_q);
            kf_d  = (k_d == '0);
            kl_d  = f_last(k_d, szk_q);
          end
        end
        DONE: begin
          if (idu_mat_mma_done_rdy) st_d = IDLE;
        end
        default: st_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge forever_cpuclk) begin
    if (cpurst) begin
      st_q  <= IDLE;
      szk_q <= '0;
      szm_q <= '0;
      szn_q <= '0;
      m_q   <= '0;
      n_q   <= '0;
      k_q   <= '0;
      len_q <= '0;
      kf_q  <= 1'b0;
      kl_q  <= 1'b0;
      dz_q  <= 1'b0;
      cnt_q <= '0;
    end else begin
      st_q  <= st_d;
      szk_q <= szk_d;
      szm_q <= szm_d;
      szn_q <= szn_d;
      m_q   <= m_d;
      n_q   <= n_d;
      k_q   <= k_d;
      len_q <= len_d;
      kf_q  <= kf_d;
      kl_q  <= kl_d;
      dz_q  <= dz_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: tb/tb_ct_mat_exu_mma_seq.sv
// Self-checking bench for ct_mat_exu_mma_seq: step-list reference model,
// per-cycle compare, directed scenarios plus randomized operations.
module tb_ct_mat_exu_mma_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_vld, start_rdy;
  logic [15:0] szk;
  logic [7:0]  szm, szn;
  logic        flush;
  logic        step_vld, step_rdy;
  logic [7:0]  m_idx, n_idx;
  logic [15:0] k_idx;
  logic [2:0]  k_len;
  logic        k_first, k_last;
  logic        done_vld, done_rdy, done_zero;
  logic        busy;
  logic [31:0] cnt;

  always #5 clk = ~clk;

  ct_mat_exu_mma_seq dut (
    .forever_cpuclk        (clk),
    .cpurst                (rst),
    .idu_mat_mma_start_vld (start_vld),
    .mat_idu_mma_start_rdy (start_rdy),
    .x_sizeK               (szk),
    .x_sizeM               (szm),
    .x_sizeN               (szn),
    .rtu_yy_xx_flush       (flush),
    .seq_mac_step_vld      (step_vld),
    .mac_seq_step_rdy      (step_rdy),
    .seq_mac_m_idx         (m_idx),
    .seq_mac_n_idx         (n_idx),
    .seq_mac_k_idx         (k_idx),
    .seq_mac_k_len         (k_len),
    .seq_mac_k_first       (k_first),
    .seq_mac_k_last        (k_last),
    .mat_idu_mma_done_vld  (done_vld),
    .idu_mat_mma_done_rdy  (done_rdy),
    .mat_idu_mma_done_zero (done_zero),
    .mat_seq_busy          (busy),
    .mat_seq_step_cnt      (cnt)
  );

  typedef struct {
    int m; int n; int k; int len; bit f; bit l;
  } step_t;

  int          vectors = 0;
  int          errs    = 0;
  int          mst     = 0;   // 0 idle, 1 issuing steps, 2 awaiting done
  bit          mzero   = 0;
  longint      mcnt    = 0;
  step_t       q[$];
  step_t       seen[$];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: on acceptance the whole step list is enumerated.
  always @(posedge clk) begin
    if (rst) begin
      mst = 0; mzero = 0; mcnt = 0; q.delete();
    end else begin
      bit x;
      x = (mst == 1) && step_rdy;
      if (x) begin
        void'(q.pop_front());
        if (mcnt != 64'hFFFF_FFFF) mcnt++;
      end
      if (flush) begin
        mst = 0; q.delete();
      end else if (mst == 0) begin
        if (start_vld) begin
          if (szk == 0 || szm == 0 || szn == 0) begin
            mst = 2; mzero = 1;
          end else begin
            for (int a = 0; a < int'(szm); a++)
              for (int b = 0; b < int'(szn); b++)
                for (int c = 0; c < int'(szk); c += 4) begin
                  step_t s;
                  s.m = a; s.n = b; s.k = c;
                  s.len = (int'(szk) - c < 4) ? int'(szk) - c : 4;
                  s.f = (c == 0);
                  s.l = (c + 4 >= int'(szk));
                  q.push_back(s);
                end
            mst = 1; mzero = 0;
          end
        end
      end else if (mst == 1) begin
        if (x && q.size() == 0) begin
          mst = 2; mzero = 0;
        end
      end else if (done_rdy) begin
        mst = 0;
      end
    end
  end

  // Compare process.
  always @(negedge clk) begin
    chk("start_rdy", start_rdy, (mst == 0 && !flush && !rst));
    chk("step_vld", step_vld, mst == 1);
    chk("done_vld", done_vld, mst == 2);
    chk("busy", busy, mst != 0);
    chk("step_cnt", cnt, mcnt);
    if (mst == 1 && q.size() > 0) begin
      chk("m_idx", m_idx, q[0].m);
      chk("n_idx", n_idx, q[0].n);
      chk("k_idx", k_idx, q[0].k);
      chk("k_len", k_len, q[0].len);
      chk("k_first", k_first, q[0].f);
      chk("k_last", k_last, q[0].l);
    end
    if (mst == 2) chk("done_zero", done_zero, mzero);
    if (step_vld && step_rdy && !rst) begin
      step_t s;
      s.m = m_idx; s.n = n_idx; s.k = k_idx;
      s.len = k_len; s.f = k_first; s.l = k_last;
      seen.push_back(s);
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // mode 0: ready always, 1: 3 stall cycles per step, 2: random
  task automatic op(input int m, input int n, input int k,
                    input int mode, input int exp);
    int budget, stc, dc;
    seen.delete();
    szm = 8'(m); szn = 8'(n); szk = 16'(k);
    start_vld = 1; step_rdy = (mode == 0); done_rdy = 0;
    cycle();
    start_vld = 0;
    chk("qlen", q.size(), exp);
    if (exp == 0) begin
      chk("zero_done_vld", done_vld, 1);
      chk("zero_done_zero", done_zero, 1);
    end
    budget = 0; stc = 0; dc = 0;
    while (mst != 0 && budget < 70000) begin
      szm = 8'($urandom); szn = 8'($urandom); szk = 16'($urandom);
      case (mode)
        0: step_rdy = 1;
        1: step_rdy = (stc % 4 == 3);
        default: step_rdy = 1'($urandom);
      endcase
      if (mode == 2) begin
        done_rdy = 1'($urandom);
        flush = ($urandom_range(0, 49) == 0);
      end else begin
        done_rdy = (dc >= 3);
      end
      if (mst == 1) stc++;
      if (mst == 2) dc++;
      cycle();
      budget++;
    end
    flush = 0; done_rdy = 0; step_rdy = 0;
    if (budget >= 70000) chk("op_timeout", 1, 0);
  endtask

  initial begin
    longint c0;
    int em[4], ek[4], el[4], ef[4], ell[4];
    rst = 1; start_vld = 0; szk = 0; szm = 0; szn = 0;
    flush = 0; step_rdy = 0; done_rdy = 0;
    repeat (3) cycle();
    chk("rst_start_rdy", start_rdy, 0);
    chk("rst_k_len", k_len, 0);
    chk("rst_k_first", k_first, 0);
    chk("rst_k_last", k_last, 0);
    chk("rst_idx", {m_idx, n_idx, k_idx}, 0);
    chk("rst_cnt", cnt, 0);
    chk("rst_done_zero", done_zero, 0);
    rst = 0;
    cycle();

    // M=2 N=1 K=6, exact sequence
    op(2, 1, 6, 0, 4);
    em = '{0, 0, 1, 1}; ek = '{0, 4, 0, 4}; el = '{4, 2, 4, 2};
    ef = '{1, 0, 1, 0}; ell = '{0, 1, 0, 1};
    chk("seq_len", seen.size(), 4);
    for (int i = 0; i < 4 && i < seen.size(); i++) begin
      chk("seq_m", seen[i].m, em[i]);
      chk("seq_n", seen[i].n, 0);
      chk("seq_k", seen[i].k, ek[i]);
      chk("seq_klen", seen[i].len, el[i]);
      chk("seq_first", seen[i].f, ef[i]);
      chk("seq_last", seen[i].l, ell[i]);
    end
    chk("seq_cnt", cnt, 4);

    // stalls
    op(1, 2, 4, 1, 2);
    chk("stall_n", seen.size(), 2);
    foreach (seen[i]) begin
      chk("stall_fl", {seen[i].f, seen[i].l}, 2'b11);
      chk("stall_len", seen[i].len, 4);
    end

    // zero size
    op(5, 5, 0, 1, 0);
    chk("zero_steps", seen.size(), 0);

    // flush after 3 transfers, with a start in the flush cycle
    c0 = mcnt;
    seen.delete();
    szm = 4; szn = 4; szk = 16; start_vld = 1; step_rdy = 1;
    cycle();
    start_vld = 0;
    repeat (3) cycle();
    step_rdy = 0; flush = 1; start_vld = 1;
    cycle();
    flush = 0; start_vld = 0;
    chk("fl_busy", busy, 0);
    chk("fl_step_vld", step_vld, 0);
    chk("fl_done_vld", done_vld, 0);
    chk("fl_cnt", cnt, c0 + 3);
    chk("fl_seen", seen.size(), 3);
    cycle();
    chk("fl_no_start", busy, 0);

    // size change mid-run
    op(2, 1, 1, 0, 2);
    chk("latch_steps", seen.size(), 2);

    // K boundary
    c0 = mcnt;
    op(1, 1, 65535, 0, 16384);
    chk("big_cnt", cnt, c0 + 16384);
    if (seen.size() > 0) begin
      chk("big_k", seen[$].k, 65532);
      chk("big_len", seen[$].len, 3);
      chk("big_last", seen[$].l, 1);
    end else chk("big_seen", 0, 1);

    // reset mid-run
    szm = 3; szn = 3; szk = 8; start_vld = 1; step_rdy = 1;
    cycle();
    start_vld = 0;
    repeat (5) cycle();
    rst = 1;
    cycle(); cycle();
    chk("mr_busy", busy, 0);
    chk("mr_done_vld", done_vld, 0);
    chk("mr_cnt", cnt, 0);
    chk("mr_k_len", k_len, 0);
    rst = 0; step_rdy = 0;
    cycle();

    for (int i = 0; i < 40; i++) begin
      int m, n, k;
      m = $urandom_range(0, 3);
      n = $urandom_range(0, 3);
      k = $urandom_range(0, 12);
      op(m, n, k, 2, m * n * ((k + 3) / 4));
    end
    repeat (2) cycle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule

// File: doc/ct_mat_exu_mma_seq.md
CT_MAT_EXU_MMA_SEQ -- requirements
Module: ct_mat_exu_mma_seq

Interface
REQ-001 SHALL have parameter K_CHUNK, default 4, the number of K elements per MAC step (power of 2, at least 2).
REQ-002 SHALL have parameter KLEN_WIDTH, default 3 ($clog2(K_CHUNK)+1), the width of seq_mac_k_len.
REQ-003 SHALL have these ports, one per line (name, direction, width, meaning):
- forever_cpuclk  in  1  sole clock; all state on rising edge.
- cpurst  in  1  synchronous, active-high reset.
- idu_mat_mma_start_vld  in  1  MMA instruction start request.
- mat_idu_mma_start_rdy  out  1  sequencer can accept a start.
- x_sizeK  in  16  configured K, from the config unit.
- x_sizeM  in  8  configured M.
- x_sizeN  in  8  configured N.
- rtu_yy_xx_flush  in  1  pipeline flush.
- seq_mac_step_vld  out  1  MAC step valid.
- mac_seq_step_rdy  in  1  MAC array accepts the step.
- seq_mac_m_idx  out  8  output row index.
- seq_mac_n_idx  out  8  output column index.
- seq_mac_k_idx  out  16  first K element of the step.
- seq_mac_k_len  out  KLEN_WIDTH  valid K elements in the step, 1..K_CHUNK.
- seq_mac_k_first  out  1  first K chunk of an (m,n) element; MAC clears its accumulator.
- seq_mac_k_last  out  1  last K chunk of an (m,n) element; MAC writes back.
- mat_idu_mma_done_vld  out  1  operation complete.
- idu_mat_mma_done_rdy  in  1  completion accepted.
- mat_idu_mma_done_zero  out  1  completion issued zero steps.
- mat_seq_busy  out  1  state is not IDLE.
- mat_seq_step_cnt  out  32  saturating count of accepted steps.

Function
REQ-004 SHALL use three states: IDLE, RUN and DONE.
REQ-005 SHALL drive start_rdy = (state==IDLE) && !flush && !cpurst.
- A start is accepted on start_vld && start_rdy.
REQ-006 SHALL latch sizeK, sizeM and sizeN in the acceptance cycle.
- Later changes to x_size* SHALL NOT affect an operation in progress.
REQ-007 On acceptance, if any latched size is 0, SHALL go to DONE with done_zero=1 and issue no steps.
- Otherwise it SHALL go to RUN with m=n=k=0.
REQ-008 In RUN, step_vld SHALL be 1 and step outputs SHALL come from registers (no combinational path from inputs).
REQ-009 A step transfers on step_vld && step_rdy.
- All step outputs SHALL hold stable while step_vld && !step_rdy.
REQ-010 Loop order SHALL be k innermost (step K_CHUNK), then n, then m.
- On each transfer: advance k; at the last chunk, reset k to 0 and increment n.
- At n == N-1 with the last chunk, reset n to 0 and increment m.
REQ-011 Chunk fields SHALL be:
- k_len = min(K_CHUNK, sizeK - k_idx).
- k_first = (k_idx == 0).
- k_last = (k_idx + K_CHUNK >= sizeK), computed in 17 bits with no overflow at sizeK = 65535.
REQ-012 The transfer of the final step (m=M-1, n=N-1, k_last) SHALL move the state to DONE next cycle with done_zero=0.
- step_vld SHALL drop to 0 in that cycle.
REQ-013 In DONE, done_vld SHALL be 1 until done_vld && done_rdy, then the state SHALL return to IDLE.
- A new start SHALL NOT be accepted in that same cycle.
REQ-014 Total steps SHALL be M*N*ceil(K/K_CHUNK).
REQ-015 rtu_yy_xx_flush SHALL have priority over every other event.
- Next state SHALL be IDLE, and step_vld and done_vld SHALL drop next cycle.
- A start presented with flush SHALL NOT be accepted.
- A step transfer in the flush cycle SHALL still be counted.
REQ-016 step_cnt SHALL increment by 1 per step transfer, saturate at 0xFFFFFFFF, and clear only on reset.
REQ-017 In IDLE, index outputs SHALL hold their last values; they are don't-care when step_vld=0.
REQ-018 busy SHALL be 1 exactly when the state is RUN or DONE.

Reset
REQ-019 While cpurst=1, on each clock edge the block SHALL set:
- state=IDLE; step_vld=0, done_vld=0, done_zero=0.
- m, n, k indices=0, k_len=0, k_first=0, k_last=0.
- step_cnt=0, busy=0, latched sizes=0.
- start_rdy SHALL be 0 while reset is asserted.
REQ-020 Reset asserted mid-RUN or mid-DONE SHALL abort the operation with no done pulse.

Verification
REQ-021 M=2, N=1, K=6, step_rdy=1 SHALL produce, in order:
- (m0,n0,k0,len4,first), (m0,n0,k4,len2,last), (m1,n0,k0,len4,first), (m1,n0,k4,len2,last).
- Then done_vld=1 with done_zero=0, and step_cnt=4.
REQ-022 M=1, N=2, K=4 with step_rdy low 3 cycles per step SHALL give:
- 2 steps, each with first=last=1 and len4.
- Outputs constant during stalls.
REQ-023 Start with K=0, M=5, N=5 SHALL give:
- No step_vld.
- done_vld=1 with done_zero=1 one cycle after acceptance.
- done held until done_rdy, then start_rdy=1 the following cycle.
REQ-024 M=4, N=4, K=16 with flush after the 3rd transfer SHALL give:
- step_vld=0 and busy=0 next cycle, no done_vld, step_cnt=3.
- A start in the flush cycle is not accepted.
REQ-025 Changing x_sizeM from 2 to 7 mid-RUN of M=2, N=1, K=1 SHALL still issue exactly 2 steps.
REQ-026 K=65535, M=1, N=1 SHALL end with a final step of k_idx=65532, len3, last=1, and step_cnt=16384.
